// File: rtl/wb_hazard_tracker.sv
// Scoreboard of in-flight register writes between decode and writeback, with a
// single outstanding multdiv tracker and sticky error flags.
module wb_hazard_tracker #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rwe,
    input  logic        issue_long,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rs_b,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rwe,
    input  logic        md_ready,
    output logic        stall,
    output logic [31:0] pending,
    output logic        md_busy,
    output logic [4:0]  md_rd,
    output logic        err_ovf,
    output logic        err_udf,
    output logic        err_tmo
);

    localparam int TW = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [4:0]      r_md_rd;
    logic            r_err_ovf;
    logic            r_err_udf;
    logic            r_err_tmo;
    logic [1:0]      r_cnt [1:31];

    logic            w_accept;
    logic            w_md_block;
    logic [31:0]     w_inc;
    logic [31:0]     w_retire;
    logic [31:0]     w_pending;
    logic [31:0]     w_hazard;
    logic [31:0]     w_full;
    logic [31:0]     w_empty;
    logic            w_ovf;
    logic            w_udf;

    assign w_retire = (wb_valid && wb_rwe && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
    assign w_inc    = (w_accept && issue_rwe && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;

    // A count of one retiring this very cycle is already safe to read (bypassed value).
    always_comb begin
        w_pending = 32'd0;
        w_hazard  = 32'd0;
        w_full    = 32'd0;
        w_empty   = 32'd0;
        for (int n = 1; n < 32; n++) begin
            w_pending[n] = (r_cnt[n] != 2'd0);
            w_hazard[n]  = r_cnt[n][1] | ((r_cnt[n] == 2'd1) & ~w_retire[n]);
            w_full[n]    = (r_cnt[n] == 2'd3);
            w_empty[n]   = (r_cnt[n] == 2'd0);
        end
    end

    assign w_md_block = (r_state == S_BUSY) &
                        (issue_long |
                         (issue_rwe & (issue_rd == r_md_rd)) |
                         ((rs_a != 5'd0) & (rs_a == r_md_rd)) |
                         ((rs_b != 5'd0) & (rs_b == r_md_rd)));

    assign stall    = issue_valid & (w_hazard[rs_a] | w_hazard[rs_b] | w_md_block);
    assign w_accept = issue_valid & ~stall;

    assign w_ovf = |(w_inc & ~w_retire & w_full);
    assign w_udf = |(w_retire & ~w_inc & w_empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 1; n < 32; n++) begin
                r_cnt[n] <= 2'd0;
            end
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            for (int n = 1; n < 32; n++) begin
                if (w_inc[n] && !w_retire[n]) begin
                    if (r_cnt[n] != 2'd3) r_cnt[n] <= r_cnt[n] + 2'd1;
                end else if (w_retire[n] && !w_inc[n]) begin
                    if (r_cnt[n] != 2'd0) r_cnt[n] <= r_cnt[n] - 2'd1;
                end
            end
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_udf) r_err_udf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_md_rd   <= 5'd0;
            r_err_tmo <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && issue_long) begin
                        r_state <= S_BUSY;
                        r_md_rd <= issue_rd;
                        r_timer <= '0;
                    end
                end
                S_BUSY: begin
                    if (md_ready) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == TMO_LAST) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pending = w_pending;
    assign md_busy = (r_state == S_BUSY);
    assign md_rd   = r_md_rd;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
    assign err_tmo = r_err_tmo;

endmodule

// File: tb/tb_wb_hazard_tracker.sv
// Directed and randomized checks of wb_hazard_tracker against a counting model
// of in-flight writes and an outstanding-multdiv record.
module tb_wb_hazard_tracker;

  localparam int MD_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_rwe = 1'b0;
  logic        issue_long = 1'b0;
  logic [4:0]  rs_a = '0;
  logic [4:0]  rs_b = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        wb_rwe = 1'b0;
  logic        md_ready = 1'b0;
  logic        stall;
  logic [31:0] pending;
  logic        md_busy;
  logic [4:0]  md_rd;
  logic        err_ovf;
  logic        err_udf;
  logic        err_tmo;

  wb_hazard_tracker #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rwe(issue_rwe),
    .issue_long(issue_long), .rs_a(rs_a), .rs_b(rs_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rwe(wb_rwe), .md_ready(md_ready),
    .stall(stall), .pending(pending), .md_busy(md_busy), .md_rd(md_rd),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: number of outstanding writes per register, plus the
  // edge index at which the current multdiv op was launched.
  int m_cnt [32];
  bit m_busy;
  int m_mdrd;
  int m_start;
  int m_cyc;
  bit m_ovf, m_udf, m_tmo;

  task automatic model_clear();
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    m_busy = 0; m_mdrd = 0; m_start = 0; m_cyc = 0;
    m_ovf = 0; m_udf = 0; m_tmo = 0;
  endtask

  function automatic bit retiring(int r);
    return wb_valid && wb_rwe && wb_rd != 0 && int'(wb_rd) == r;
  endfunction

  function automatic bit src_hazard(int rs);
    if (rs == 0) return 0;
    return (m_cnt[rs] >= 2) || (m_cnt[rs] == 1 && !retiring(rs));
  endfunction

  function automatic bit exp_stall();
    bit blk;
    blk = m_busy && (issue_long || (issue_rwe && int'(issue_rd) == m_mdrd) ||
                     (rs_a != 0 && int'(rs_a) == m_mdrd) ||
                     (rs_b != 0 && int'(rs_b) == m_mdrd));
    return issue_valid && (src_hazard(int'(rs_a)) || src_hazard(int'(rs_b)) || blk);
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    for (int n = 1; n < 32; n++) p[n] = (m_cnt[n] > 0);
    return p;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("stall", 32'(stall), 32'(exp_stall()));
    check("pending", pending, exp_pending());
    check("md_busy", 32'(md_busy), 32'(m_busy));
    check("md_rd", 32'(md_rd), 32'(m_mdrd));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_udf", 32'(err_udf), 32'(m_udf));
    check("err_tmo", 32'(err_tmo), 32'(m_tmo));
  endtask

  // Advance the model across one rising edge using the inputs held during it.
  task automatic model_edge();
    bit acc, inc, dec;
    int ir, wr;
    acc = issue_valid && !exp_stall();
    ir = int'(issue_rd);
    wr = int'(wb_rd);
    inc = acc && issue_rwe && ir != 0;
    dec = wb_valid && wb_rwe && wr != 0;
    for (int n = 1; n < 32; n++) begin
      bit i_n, d_n;
      i_n = inc && ir == n;
      d_n = dec && wr == n;
      if (i_n && !d_n) begin
        if (m_cnt[n] == 3) m_ovf = 1; else m_cnt[n]++;
      end else if (d_n && !i_n) begin
        if (m_cnt[n] == 0) m_udf = 1; else m_cnt[n]--;
      end
    end
    m_cyc++;
    if (m_busy) begin
      if (md_ready) m_busy = 0;
      else if (m_cyc - m_start == MD_TIMEOUT) begin
        m_busy = 0;
        m_tmo = 1;
      end
    end else if (acc && issue_long) begin
      m_busy = 1;
      m_mdrd = ir;
      m_start = m_cyc;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(bit iv, int rd, bit rwe, bit lng, int ra, int rb,
                       bit wv, int wrd, bit wwe, bit mdr);
    issue_valid = iv; issue_rd = 5'(rd); issue_rwe = rwe; issue_long = lng;
    rs_a = 5'(ra); rs_b = 5'(rb);
    wb_valid = wv; wb_rd = 5'(wrd); wb_rwe = wwe; md_ready = mdr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();
    #1;
    check("reset_pending", pending, 32'd0);
    check("reset_busy", 32'(md_busy), 32'd0);
    compare_all();

    // Issue to r5, then a reader stalls until the write retires in the same cycle.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0, 0); #1;
    check("raw_stall", 32'(stall), 32'd1);
    check("raw_pend5", 32'(pending[5]), 32'd1);
    tick();
    drive(1, 0, 0, 0, 5, 0, 1, 5, 1, 0); #1;
    check("raw_bypass", 32'(stall), 32'd0);
    tick();
    idle(); #1;
    check("raw_clear5", 32'(pending[5]), 32'd0);

    // Register zero never tracks.
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("r0_pending", pending, 32'd0);
    check("r0_stall", 32'(stall), 32'd0);
    tick();

    // Saturation on r7, then drain.
    repeat (4) begin drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick(); end
    check("sat_ovf", 32'(err_ovf), 32'd1);
    check("sat_pend7", 32'(pending[7]), 32'd1);
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 0); tick(); end
    idle(); #1;
    check("drain_pend7", 32'(pending[7]), 32'd0);
    check("drain_udf", 32'(err_udf), 32'd0);
    tick();

    // Multdiv to r9 blocks conflicting issues only.
    drive(1, 9, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    check("md_busy_on", 32'(md_busy), 32'd1);
    check("md_rd_9", 32'(md_rd), 32'd9);
    drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0); #1; check("md_blk_long", 32'(stall), 32'd1); tick();
    drive(1, 2, 1, 0, 0, 9, 0, 0, 0, 0); #1; check("md_blk_rsb", 32'(stall), 32'd1); tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1; check("md_blk_waw", 32'(stall), 32'd1); tick();
    drive(1, 2, 1, 0, 3, 4, 0, 0, 0, 0); #1; check("md_free", 32'(stall), 32'd0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("md_done", 32'(md_busy), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 2, 1, 0); tick();

    // Timeout after MD_TIMEOUT edges without md_ready.
    drive(1, 10, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    idle();
    repeat (MD_TIMEOUT - 1) tick();
    check("tmo_not_yet", 32'(err_tmo), 32'd0);
    check("tmo_still_busy", 32'(md_busy), 32'd1);
    tick();
    check("tmo_set", 32'(err_tmo), 32'd1);
    check("tmo_idle", 32'(md_busy), 32'd0);

    // Asynchronous reset in the middle of a multdiv with r3 outstanding.
    do_reset();
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    idle();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("arst_pending", pending, 32'd0);
    check("arst_busy", 32'(md_busy), 32'd0);
    check("arst_mdrd", 32'(md_rd), 32'd0);
    check("arst_errs", {29'd0, err_ovf, err_udf, err_tmo}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("arst_late_ready", 32'(md_busy), 32'd0);
    check("arst_no_tmo", 32'(err_tmo), 32'd0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0);
      tick();
    end
    idle(); #1;
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_hazard_tracker.md
WB_HAZARD_TRACKER -- requirements
Module: wb_hazard_tracker

Interface
REQ-001 Parameter: MD_TIMEOUT, default 40, max cycles a multdiv op may stay outstanding before error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-004 issue_valid  in  1  decode stage presents an instruction.
REQ-005 issue_rd  in  5  destination register of the issuing instruction.
REQ-006 issue_rwe  in  1  issuing instruction writes the register file.
REQ-007 issue_long  in  1  issuing instruction is a multdiv op.
REQ-008 rs_a, rs_b  in  5 each  source registers read by the issuing instruction.
REQ-009 wb_valid  in  1  writeback stage holds a valid instruction this cycle.
REQ-010 wb_rd  in  5  writeback destination (post-Jal/status remap: 31 or 30 already applied).
REQ-011 wb_rwe  in  1  writeback stage writes the register file.
REQ-012 md_ready  in  1  multdiv unit result ready (one-cycle pulse).
REQ-013 stall  out  1  decode must hold; issue not accepted.
REQ-014 pending  out  32  bit n set when register n has at least one outstanding write.
REQ-015 md_busy  out  1  multdiv op outstanding.
REQ-016 md_rd  out  5  destination of outstanding multdiv op.
REQ-017 err_ovf, err_udf, err_tmo  out  1 each  sticky counter overflow, counter underflow, multdiv timeout.

Function
REQ-018 Accept = issue_valid & !stall; only accepted issues change state.
REQ-019 Per-register 2-bit in-flight counter cnt[1..31]; register 0 has none, never pending, never stalls.
REQ-020 Accepted issue with issue_rwe and issue_rd!=0 increments cnt[issue_rd] at the edge.
REQ-021 wb_valid & wb_rwe & wb_rd!=0 decrements cnt[wb_rd] at the edge.
REQ-022 Increment and decrement of same register in same cycle leave cnt unchanged.
REQ-023 Increment at cnt==3: cnt stays 3, err_ovf set; decrement at cnt==0: cnt stays 0, err_udf set.
REQ-024 pending[n] = (cnt[n]!=0), combinational from registered counters; pending[0]=0.
REQ-025 Source hazard on rs (rs!=0): cnt[rs]>=2, or cnt[rs]==1 and not (wb_valid & wb_rwe & wb_rd==rs); a retiring write resolves the hazard same cycle.
REQ-026 stall = issue_valid & (hazard on rs_a | hazard on rs_b | md_block); combinational, zero-cycle.
REQ-027 md_block, state BUSY only: issue_long, or issue_rd==md_rd with issue_rwe, or rs_a/rs_b==md_rd (nonzero).
REQ-028 FSM IDLE: accepted issue_long -> BUSY, latch md_rd=issue_rd, clear timer.
REQ-029 FSM BUSY: md_ready -> IDLE next edge; else timer increments; timer==MD_TIMEOUT-1 -> err_tmo set, -> IDLE.
REQ-030 md_busy = (state==BUSY); md_rd holds last latched value in IDLE.
REQ-031 md_ready in IDLE ignored, no error.
REQ-032 Error flags sticky until reset; they do not block operation.

Reset
REQ-033 reset low: all cnt=0, pending=0, FSM IDLE, timer=0, md_busy=0, md_rd=0, all err=0, regardless of clk.
REQ-034 reset deasserted mid-BUSY-operation restarts in IDLE; a later md_ready is ignored.
REQ-035 stall depends only on current inputs and state; reset state gives stall=0 for any hazard-free input.

Verification
REQ-036 Issue rd=5 rwe; next cycle issue rs_a=5 -> stall=1, pending[5]=1; wb_rd=5 wb_rwe pulse same cycle -> stall=0 that cycle, pending[5]=0 after edge.
REQ-037 Issue rd=0 rwe, then rs_a=0 -> pending=0, stall=0, no err.
REQ-038 Four accepted issues to rd=7 without writeback -> cnt saturates at 3, err_ovf=1; three writebacks -> pending[7]=0.
REQ-039 Issue multdiv rd=9; subsequent multdiv, rs_b=9, or rd=9 writes -> stall=1 while md_busy; md_ready -> md_busy=0 next edge, unrelated issues never stalled.
REQ-040 Multdiv issued, no md_ready for 40 cycles -> err_tmo=1 at cycle 40, md_busy=0.
REQ-041 reset low asynchronously mid-BUSY with pending[3]=1 -> all outputs 0 before next clk edge.
